// File: rtl/imem_loader.sv
// Boot loader: assembles a length-prefixed, XOR-checksummed byte stream into
// little-endian instruction words, writes them to imem, then releases the core.
module imem_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;

  state_t              state_reg, state_next;
  logic [7:0]          len_lo_reg, len_lo_next;
  logic [15:0]         len_reg, len_next;
  logic [ADDR_W-1:0]   word_idx_reg, word_idx_next;
  logic [1:0]          byte_idx_reg, byte_idx_next;
  logic [7:0]          csum_reg, csum_next;
  logic [23:0]         lanes_reg, lanes_next;
  logic                we_reg, we_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [31:0]         wdata_reg, wdata_next;

  logic                loading;
  logic                accept;
  logic [15:0]         len_full;

  assign loading  = (state_reg == LEN0) || (state_reg == LEN1) ||
                    (state_reg == DATA) || (state_reg == CSUM);
  // rst gates in_ready combinationally so nothing is offered during reset
  assign in_ready = !rst && !reload && loading;
  assign accept   = in_valid && in_ready;
  assign len_full = {in_data, len_lo_reg};

  assign imem_we    = we_reg;
  assign imem_addr  = addr_reg;
  assign imem_wdata = wdata_reg;
  assign done       = (state_reg == DONE);
  assign err        = (state_reg == ERR);
  assign cpu_rst_n  = (state_reg == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= LEN0;
      len_lo_reg   <= '0;
      len_reg      <= '0;
      word_idx_reg <= '0;
      byte_idx_reg <= '0;
      csum_reg     <= '0;
      lanes_reg    <= '0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      len_lo_reg   <= len_lo_next;
      len_reg      <= len_next;
      word_idx_reg <= word_idx_next;
      byte_idx_reg <= byte_idx_next;
      csum_reg     <= csum_next;
      lanes_reg    <= lanes_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    len_lo_next   = len_lo_reg;
    len_next      = len_reg;
    word_idx_next = word_idx_reg;
    byte_idx_next = byte_idx_reg;
    csum_next     = csum_reg;
    lanes_next    = lanes_reg;
    we_next       = 1'b0;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;

    if (reload) begin
      state_next    = LEN0;
      len_lo_next   = '0;
      len_next      = '0;
      word_idx_next = '0;
      byte_idx_next = '0;
      csum_next     = '0;
      lanes_next    = '0;
    end else if (accept) begin
      case (state_reg)
        LEN0: begin
          len_lo_next = in_data;
          state_next  = LEN1;
        end
        LEN1: begin
          len_next = len_full;
          if ({1'b0, len_full} > 17'(DEPTH)) begin
            state_next = ERR;
          end else if (len_full == 16'd0) begin
            state_next = CSUM;
          end else begin
            state_next    = DATA;
            word_idx_next = '0;
            byte_idx_next = '0;
          end
        end
        DATA: begin
          csum_next     = csum_reg ^ in_data;
          byte_idx_next = byte_idx_reg + 2'd1;
          for (int i = 0; i < 3; i++) begin
            if (byte_idx_reg == 2'(i)) lanes_next[8*i +: 8] = in_data;
          end
          // Fourth byte completes the word; the write strobe follows one cycle later
          if (byte_idx_reg == 2'd3) begin
            we_next       = 1'b1;
            addr_next     = word_idx_reg;
            wdata_next    = {in_data, lanes_reg};
            word_idx_next = word_idx_reg + 1'b1;
            if (16'(word_idx_reg) == len_reg - 16'd1) state_next = CSUM;
          end
        end
        CSUM: begin
          state_next = (in_data == csum_reg) ? DONE : ERR;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a frame-level model predicts writes and the
// final status; a per-cycle compare process checks the DUT against it.
module tb_imem_loader;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              reload = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst_n;
  logic              done;
  logic              err;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .reload(reload), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_rst_n(cpu_rst_n),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // model state
  bit          started = 1'b0;
  bit          exp_loading = 1'b1;
  bit          exp_done = 1'b0;
  bit          exp_err = 1'b0;
  int          exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [7:0]  frame_q[$];
  int          write_cnt = 0;
  logic [31:0] last_wdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle compare
  initial begin
    wait (started);
    forever begin
      @(negedge clk);
      check("in_ready", 32'(in_ready), 32'(exp_loading && !reload && !rst));
      check("done", 32'(done), 32'(exp_done));
      check("err", 32'(err), 32'(exp_err));
      check("cpu_rst_n", 32'(cpu_rst_n), 32'(exp_done));
      if (imem_we === 1'b1) begin
        write_cnt++;
        last_wdata = imem_wdata;
        if (exp_addr_q.size() == 0) begin
          check("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
        end else begin
          check("write_addr", 32'(imem_addr), 32'(exp_addr_q.pop_front()));
          check("write_data", imem_wdata, exp_data_q.pop_front());
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit throttle);
    if (throttle) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Model: predicts the writes and the outcome of frame_q, then streams it.
  task automatic run_frame(input bit throttle);
    int n;
    logic [7:0] cs;
    logic [31:0] w;
    n = int'({frame_q[1], frame_q[0]});
    send_byte(frame_q[0], throttle);
    send_byte(frame_q[1], throttle);
    if (n > DEPTH) begin
      exp_loading = 1'b0;
      exp_err = 1'b1;
      return;
    end
    cs = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = '0;
      for (int k = 0; k < 4; k++) begin
        w = w | (32'(frame_q[2 + 4*i + k]) << (8*k));
        cs = cs ^ frame_q[2 + 4*i + k];
      end
      exp_addr_q.push_back(i);
      exp_data_q.push_back(w);
    end
    for (int j = 2; j < 2 + 4*n; j++) send_byte(frame_q[j], throttle);
    send_byte(frame_q[2 + 4*n], throttle);
    exp_loading = 1'b0;
    if (frame_q[2 + 4*n] == cs) exp_done = 1'b1;
    else exp_err = 1'b1;
    @(posedge clk); #1;
    check("pending_writes", 32'(exp_addr_q.size()), 32'd0);
  endtask

  task automatic send_raw();
    foreach (frame_q[j]) send_byte(frame_q[j], 1'b0);
  endtask

  task automatic do_reload();
    reload   = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(posedge clk); #1;
    reload   = 1'b0;
    in_valid = 1'b0;
    exp_loading = 1'b1;
    exp_done = 1'b0;
    exp_err = 1'b0;
  endtask

  initial begin
    #3;
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    started = 1'b1;

    // 1: normal load
    write_cnt = 0;
    frame_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h06, 8'h98, 8'h01, 8'h2C};
    run_frame(1'b0);
    check("t1_writes", 32'(write_cnt), 32'd2);
    check("t1_last_word", last_wdata, 32'h019806B3);
    check("t1_done", 32'(done), 32'd1);
    check("t1_addr_hold", 32'(imem_addr), 32'd1);
    do_reload();

    // 2: bad checksum
    write_cnt = 0;
    frame_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h06, 8'h98, 8'h01, 8'h2D};
    run_frame(1'b0);
    check("t2_writes", 32'(write_cnt), 32'd2);
    check("t2_err", 32'(err), 32'd1);
    check("t2_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    do_reload();

    // 3a: oversize header
    write_cnt = 0;
    frame_q = '{8'h41, 8'h00};
    run_frame(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t3a_writes", 32'(write_cnt), 32'd0);
    check("t3a_err", 32'(err), 32'd1);
    do_reload();

    // 3b: zero length
    frame_q = '{8'h00, 8'h00, 8'h00};
    run_frame(1'b0);
    check("t3b_writes", 32'(write_cnt), 32'd0);
    check("t3b_done", 32'(done), 32'd1);
    do_reload();

    // 4: throttled stream
    write_cnt = 0;
    frame_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h06, 8'h98, 8'h01, 8'h2C};
    run_frame(1'b1);
    check("t4_writes", 32'(write_cnt), 32'd2);
    check("t4_last_word", last_wdata, 32'h019806B3);

    // 5a: reload from DONE, one-word frame
    do_reload();
    check("t5_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    frame_q = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    run_frame(1'b0);
    check("t5a_word", last_wdata, 32'h00000013);

    // 5b: reload mid-word
    do_reload();
    frame_q = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    send_raw();
    do_reload();
    frame_q = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    run_frame(1'b0);
    check("t5b_word", last_wdata, 32'h12345678);
    check("t5b_done", 32'(done), 32'd1);

    // 6: async reset during DATA
    do_reload();
    frame_q = '{8'h01, 8'h00, 8'h11, 8'h22};
    send_raw();
    #2;
    rst = 1'b1;
    #1;
    check("t6_we", 32'(imem_we), 32'd0);
    check("t6_addr", 32'(imem_addr), 32'd0);
    check("t6_wdata", imem_wdata, 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("t6_in_ready", 32'(in_ready), 32'd0);
    exp_loading = 1'b1;
    exp_done = 1'b0;
    exp_err = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    write_cnt = 0;
    frame_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h06, 8'h98, 8'h01, 8'h2C};
    run_frame(1'b0);
    check("t6_writes", 32'(write_cnt), 32'd2);
    check("t6_last_word", last_wdata, 32'h019806B3);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
